// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
package seg_pkg;

    localparam int   BCD_W     = 4;
    localparam logic ANODE_OFF = 1'b1;
    localparam logic DOT_OFF   = 1'b1;

    // Minimum number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Refresh timebase: prescaler, digit counter, 16-step sub-slot index and frame pulse.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int CNT_W      = 16,
    parameter int DIG_W      = clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [3:0]       sub,
    output logic [DIG_W-1:0] digit_idx,
    output logic             boundary,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'((PRESCALE / 16) - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] presc_r;
    logic [CNT_W-1:0] slot_cnt_r;
    logic [3:0]       sub_r;
    logic [DIG_W-1:0] digit_r;
    logic             frame_tick_r;

    logic [CNT_W-1:0] presc_nxt_s;
    logic [CNT_W-1:0] slot_cnt_nxt_s;
    logic [3:0]       sub_nxt_s;
    logic [DIG_W-1:0] digit_nxt_s;
    logic             presc_wrap_s;
    logic             boundary_s;

    // Next-state logic; sub tracks presc / (PRESCALE/16) with a slot counter instead of a divider.
    always_comb begin
        presc_nxt_s    = presc_r;
        slot_cnt_nxt_s = slot_cnt_r;
        sub_nxt_s      = sub_r;
        digit_nxt_s    = digit_r;
        presc_wrap_s   = (presc_r == PRESC_LAST);
        boundary_s     = presc_wrap_s && (digit_r == DIG_LAST);

        if (presc_wrap_s) begin
            presc_nxt_s    = '0;
            slot_cnt_nxt_s = '0;
            sub_nxt_s      = 4'd0;
            if (digit_r == DIG_LAST) begin
                digit_nxt_s = '0;
            end else begin
                digit_nxt_s = digit_r + DIG_W'(1);
            end
        end else begin
            presc_nxt_s = presc_r + CNT_W'(1);
            if (slot_cnt_r == SLOT_LAST) begin
                slot_cnt_nxt_s = '0;
                sub_nxt_s      = sub_r + 4'd1;
            end else begin
                slot_cnt_nxt_s = slot_cnt_r + CNT_W'(1);
            end
        end
    end

    // Timebase state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r      <= '0;
            slot_cnt_r   <= '0;
            sub_r        <= 4'd0;
            digit_r      <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            presc_r      <= presc_nxt_s;
            slot_cnt_r   <= slot_cnt_nxt_s;
            sub_r        <= sub_nxt_s;
            digit_r      <= digit_nxt_s;
            frame_tick_r <= boundary_s;
        end
    end

    assign sub        = sub_r;
    assign digit_idx  = digit_r;
    assign boundary   = boundary_s;
    assign frame_tick = frame_tick_r;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with tear-free shadow loading,
// leading-zero blanking, per-digit dots and 16-level brightness PWM.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int  NUM_DIGITS = 4,
    parameter int  PRESCALE   = 50000,
    parameter int  CNT_W      = 16,
    localparam int DIG_W      = clog2(NUM_DIGITS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [BCD_W*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        load,
    input  logic                        lz_en,
    input  logic [3:0]                  brightness,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic                        dot,
    output logic [3:0]                  nibble,
    output logic [DIG_W-1:0]            digit_idx,
    output logic                        pending,
    output logic                        frame_tick
);

    localparam int DATA_W = BCD_W * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = {NUM_DIGITS{ANODE_OFF}};
    // Digit 0 sits on the most significant anode bit.
    localparam logic [NUM_DIGITS-1:0] FIRST_SEL = {1'b1, {(NUM_DIGITS-1){1'b0}}};

    logic [3:0]            sub_s;
    logic [DIG_W-1:0]      digit_idx_s;
    logic                  boundary_s;
    logic                  frame_tick_s;

    logic [DATA_W-1:0]     shadow_data_r;
    logic [NUM_DIGITS-1:0] shadow_dp_r;
    logic [DATA_W-1:0]     active_data_r;
    logic [NUM_DIGITS-1:0] active_dp_r;
    logic                  pending_r;

    logic [NUM_DIGITS-1:0] anode_r;
    logic                  dot_r;
    logic [3:0]            nibble_r;

    logic [NUM_DIGITS-1:0] blank_s;
    logic                  zero_run_s;
    logic [DATA_W-1:0]     data_shift_s;
    logic [3:0]            cur_nibble_s;
    logic                  cur_dp_s;
    logic                  cur_blank_s;
    logic                  lit_s;
    logic [NUM_DIGITS-1:0] anode_nxt_s;
    logic                  dot_nxt_s;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .CNT_W      (CNT_W),
        .DIG_W      (DIG_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .sub        (sub_s),
        .digit_idx  (digit_idx_s),
        .boundary   (boundary_s),
        .frame_tick (frame_tick_s)
    );

    // Shadow/active data path: new data only reaches the display at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_r <= '0;
            shadow_dp_r   <= '0;
            active_data_r <= '0;
            active_dp_r   <= '0;
            pending_r     <= 1'b0;
        end else if (boundary_s) begin
            // A load landing on the boundary itself bypasses the shadow.
            if (load) begin
                active_data_r <= data_in;
                active_dp_r   <= dp_in;
                pending_r     <= 1'b0;
            end else if (pending_r) begin
                active_data_r <= shadow_data_r;
                active_dp_r   <= shadow_dp_r;
                pending_r     <= 1'b0;
            end
        end else if (load) begin
            shadow_data_r <= data_in;
            shadow_dp_r   <= dp_in;
            pending_r     <= 1'b1;
        end
    end

    // Leading-zero mask: a digit blanks while every digit up to it is a plain zero.
    always_comb begin
        blank_s    = '0;
        zero_run_s = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_run_s = zero_run_s
                       & (active_data_r[k*BCD_W +: BCD_W] == 4'd0)
                       & ~active_dp_r[k];
            blank_s[k] = lz_en & zero_run_s & (k < NUM_DIGITS - 1);
        end
    end

    // Current-digit selection, PWM gating and next output values.
    always_comb begin
        data_shift_s = active_data_r >> {digit_idx_s, 2'b00};
        cur_nibble_s = data_shift_s[BCD_W-1:0];
        cur_dp_s     = active_dp_r[digit_idx_s];
        cur_blank_s  = blank_s[digit_idx_s];
        lit_s        = enable & (sub_s <= brightness) & ~cur_blank_s;
        anode_nxt_s  = ANODE_ALL_OFF;
        dot_nxt_s    = DOT_OFF;

        if (lit_s) begin
            anode_nxt_s = ~(FIRST_SEL >> digit_idx_s);
        end else begin
            anode_nxt_s = ANODE_ALL_OFF;
        end

        if (lit_s && cur_dp_s) begin
            dot_nxt_s = ~DOT_OFF;
        end else begin
            dot_nxt_s = DOT_OFF;
        end
    end

    // Registered output stage so the anode lines never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_r  <= ANODE_ALL_OFF;
            dot_r    <= DOT_OFF;
            nibble_r <= 4'd0;
        end else begin
            anode_r  <= anode_nxt_s;
            dot_r    <= dot_nxt_s;
            nibble_r <= cur_nibble_s;
        end
    end

    assign anode      = anode_r;
    assign dot        = dot_r;
    assign nibble     = nibble_r;
    assign digit_idx  = digit_idx_s;
    assign pending    = pending_r;
    assign frame_tick = frame_tick_s;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=16): stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [3:0]  anode;
    logic        dot;
    logic [3:0]  nibble;
    logic [1:0]  digit_idx;
    logic        pending;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in), .dp_in(dp_in),
        .load(load), .lz_en(lz_en), .brightness(brightness), .anode(anode), .dot(dot),
        .nibble(nibble), .digit_idx(digit_idx), .pending(pending), .frame_tick(frame_tick)
    );

    // care bits: 0 anode, 1 dot, 2 nibble, 3 pending, 4 frame_tick, 5 digit_idx
    typedef struct {
        int         stamp;
        logic [5:0] care;
        logic [3:0] anode;
        logic       dot;
        logic [3:0] nibble;
        logic       pending;
        logic       ftick;
        logic [1:0] didx;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   rel   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Lit anode pattern per digit (digit 0 is the MSB anode).
    function automatic logic [3:0] an(input int d);
        case (d)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            3:       return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic push_abs(input int stamp, input string name, input logic [5:0] care,
                            input logic [3:0] a, input logic d, input logic [3:0] n,
                            input logic p, input logic f, input logic [1:0] i);
        exp_t e;
        e.stamp = stamp; e.name = name; e.care = care; e.anode = a; e.dot = d;
        e.nibble = n; e.pending = p; e.ftick = f; e.didx = i;
        sb.push_back(e);
    endtask

    // Registered outputs seen after the edge that leaves scan state t.
    task automatic exp_out(input int t, input logic [3:0] a, input logic d,
                           input logic [3:0] n, input string name);
        push_abs(rel + t + 1, $sformatf("%s t=%0d", name, t), 6'b000111, a, d, n,
                 1'b0, 1'b0, 2'd0);
    endtask

    // State-level outputs (pending, frame_tick, digit_idx) while in scan state t.
    task automatic exp_stat(input int t, input logic p, input logic f, input string name);
        push_abs(rel + t, $sformatf("%s t=%0d", name, t), 6'b111000, 4'hF, 1'b1, 4'h0,
                 p, f, 2'((t / 16) % 4));
    endtask

    task automatic exp_reset(input int stamp, input string name);
        push_abs(stamp, name, 6'b111111, 4'b1111, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic wait_t(input int t);
        int guard;
        guard = 0;
        while ((cyc - rel) < t && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // Monitor: compare every expectation whose cycle stamp has arrived.
    always @(negedge clk) begin
        exp_t e;
        logic bad;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].stamp <= cyc) begin
                e = sb[i];
                sb.delete(i);
                n_cmp++;
                if (e.stamp < cyc) begin
                    n_bad++;
                    $display("FAIL %s: expectation for cycle %0d not checked until %0d",
                             e.name, e.stamp, cyc);
                end else begin
                    bad = (e.care[0] && anode !== e.anode) || (e.care[1] && dot !== e.dot) ||
                          (e.care[2] && nibble !== e.nibble) ||
                          (e.care[3] && pending !== e.pending) ||
                          (e.care[4] && frame_tick !== e.ftick) ||
                          (e.care[5] && digit_idx !== e.didx);
                    if (bad) begin
                        n_bad++;
                        $display("FAIL %s: got anode=%b dot=%b nibble=%h pending=%b tick=%b idx=%0d, want anode=%b dot=%b nibble=%h pending=%b tick=%b idx=%0d (care=%b)",
                                 e.name, anode, dot, nibble, pending, frame_tick, digit_idx,
                                 e.anode, e.dot, e.nibble, e.pending, e.ftick, e.didx, e.care);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
        load = 1'b0; lz_en = 1'b0; brightness = 4'd15;
        repeat (2) @(negedge clk);
        exp_reset(cyc + 1, "reset_state");
        @(negedge clk);
        rel = cyc;
        rst_n = 1'b1;

        // Scan order and frame pulse over two frames.
        for (int t = 0; t < 128; t++) begin
            exp_out(t, an((t / 16) % 4), 1'b1, 4'h0, "scan");
            exp_stat(t + 1, 1'b0, ((t + 1) % 64) == 0, "tick");
        end

        // Shadow load mid-frame; digit k is nibble k, so display "1234" is 16'h4321.
        wait_t(140);
        exp_stat(148, 1'b0, 1'b0, "pend_before");
        exp_stat(149, 1'b1, 1'b0, "pend_set");
        exp_stat(191, 1'b1, 1'b0, "pend_hold");
        exp_stat(192, 1'b0, 1'b1, "pend_clear");
        exp_out(190, 4'b1110, 1'b1, 4'h0, "old_data");
        exp_out(192, 4'b0111, 1'b1, 4'h1, "new_d0");
        exp_out(208, 4'b1011, 1'b1, 4'h2, "new_d1");
        exp_out(224, 4'b1101, 1'b1, 4'h3, "new_d2");
        exp_out(240, 4'b1110, 1'b1, 4'h4, "new_d3");
        wait_t(148); data_in = 16'h4321; load = 1'b1;
        wait_t(149); data_in = 16'h0000; load = 1'b0;

        // Two loads in one frame: last one ("5678") wins.
        wait_t(250);
        exp_stat(271, 1'b1, 1'b0, "pend2_set");
        exp_stat(319, 1'b1, 1'b0, "pend2_hold");
        exp_stat(320, 1'b0, 1'b1, "pend2_clear");
        exp_out(300, 4'b1101, 1'b1, 4'h3, "old2_d2");
        exp_out(320, 4'b0111, 1'b1, 4'h5, "last_d0");
        exp_out(336, 4'b1011, 1'b1, 4'h6, "last_d1");
        exp_out(352, 4'b1101, 1'b1, 4'h7, "last_d2");
        exp_out(368, 4'b1110, 1'b1, 4'h8, "last_d3");
        wait_t(270); data_in = 16'h1111; load = 1'b1;
        wait_t(271); load = 1'b0;
        wait_t(290); data_in = 16'h8765; load = 1'b1;
        wait_t(291); load = 1'b0;

        // Leading-zero blanking of display "0042".
        wait_t(400); data_in = 16'h2400; dp_in = 4'b0000; lz_en = 1'b1; load = 1'b1;
        exp_out(450, 4'b1111, 1'b1, 4'h0, "blank_d0");
        exp_out(470, 4'b1111, 1'b1, 4'h0, "blank_d1");
        exp_out(490, 4'b1101, 1'b1, 4'h4, "lit_d2");
        exp_out(500, 4'b1110, 1'b1, 4'h2, "lit_d3");
        wait_t(401); load = 1'b0;

        // Dot on digit 1 stops blanking there; digit 0 stays blank.
        wait_t(480); dp_in = 4'b0010; load = 1'b1;
        exp_out(515, 4'b1111, 1'b1, 4'h0, "dp_blank_d0");
        exp_out(530, 4'b1011, 1'b0, 4'h0, "dp_lit_d1");
        exp_out(550, 4'b1101, 1'b1, 4'h4, "dp_d2");
        exp_out(570, 4'b1110, 1'b1, 4'h2, "dp_d3");
        wait_t(481); load = 1'b0;

        // All zeros: only the last digit stays lit.
        wait_t(560); data_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
        exp_out(580, 4'b1111, 1'b1, 4'h0, "zero_d0");
        exp_out(600, 4'b1111, 1'b1, 4'h0, "zero_d1");
        exp_out(630, 4'b1110, 1'b1, 4'h0, "zero_last");
        wait_t(561); load = 1'b0;

        wait_t(600); data_in = 16'h4321; dp_in = 4'b0010; load = 1'b1;
        wait_t(601); load = 1'b0;

        // Brightness 3 then 0, then enable gating.
        wait_t(630);
        for (int p = 0; p < 16; p++) begin
            exp_out(640 + p, (p <= 3) ? 4'b0111 : 4'b1111, 1'b1, 4'h1, "bright3_d0");
            exp_out(672 + p, (p <= 3) ? 4'b1101 : 4'b1111, 1'b1, 4'h3, "bright3_d2");
            exp_out(688 + p, (p == 0) ? 4'b1110 : 4'b1111, 1'b1, 4'h4, "bright0_d3");
        end
        exp_out(724, 4'b1011, 1'b0, 4'h2, "en_on");
        exp_out(725, 4'b1111, 1'b1, 4'h2, "en_off");
        exp_out(730, 4'b1011, 1'b0, 4'h2, "en_back");
        wait_t(640); brightness = 4'd3; lz_en = 1'b0;
        wait_t(688); brightness = 4'd0;
        wait_t(704); brightness = 4'd15;
        wait_t(725); enable = 1'b0;
        wait_t(730); enable = 1'b1;

        // Async reset at digit 2, presc 7, with a load pending.
        wait_t(800);
        exp_out(805, 4'b1101, 1'b1, 4'h3, "pre_rst_d2");
        exp_stat(803, 1'b1, 1'b0, "pre_rst_pend");
        exp_reset(rel + 807, "async_reset");
        wait_t(801); data_in = 16'h7777; load = 1'b1;
        wait_t(802); load = 1'b0;
        wait_t(806);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        exp_reset(cyc + 1, "reset_hold");
        @(negedge clk);
        @(negedge clk);
        rel = cyc;
        rst_n = 1'b1;

        // Restart from digit 0, then load on the boundary cycle.
        exp_out(0, 4'b0111, 1'b1, 4'h0, "restart_d0");
        exp_stat(1, 1'b0, 1'b0, "restart_idx");
        exp_out(16, 4'b1011, 1'b1, 4'h0, "restart_d1");
        exp_out(62, 4'b1110, 1'b1, 4'h0, "bnd_old");
        exp_stat(63, 1'b0, 1'b0, "bnd_cycle");
        exp_stat(64, 1'b0, 1'b1, "bnd_no_pend");
        exp_stat(65, 1'b0, 1'b0, "bnd_after");
        exp_out(64, 4'b0111, 1'b1, 4'h9, "bnd_d0");
        exp_out(80, 4'b1011, 1'b1, 4'h9, "bnd_d1");
        exp_out(127, 4'b1110, 1'b1, 4'h9, "bnd_d3");
        wait_t(63); data_in = 16'h9999; dp_in = 4'b0000; load = 1'b1;
        wait_t(64); data_in = 16'h0000; load = 1'b0;
        wait_t(130);

        for (int k = 0; k < 300 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked", sb.size());
            n_cmp += sb.size();
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
